// File: rtl/bruteforce_scheduler_if.sv
// Control and engine-bank signals of the brute-force scheduler.
// The scheduler uses the slave view; the control logic and engine array use the master view.
interface bruteforce_scheduler_if #(
    parameter int NUM_WORKERS = 4
);
    logic                             start;
    logic                             abort;
    logic [127:0]                     target;
    logic [7:0]                       target_length;
    logic [NUM_WORKERS-1:0]           worker_enable;
    logic [NUM_WORKERS-1:0][7:0]      worker_start_pos;
    logic [2:0]                       worker_increment;
    logic [NUM_WORKERS-1:0][7:0]      worker_word_length;
    logic [NUM_WORKERS-1:0][127:0]    worker_password;
    logic                             busy;
    logic                             found;
    logic                             exhausted;
    logic [127:0]                     result_password;
    logic [2:0]                       result_worker;
    logic [31:0]                      cycle_count;

    modport slave (
        input  start, abort, target, target_length, worker_word_length, worker_password,
        output worker_enable, worker_start_pos, worker_increment, busy, found, exhausted,
               result_password, result_worker, cycle_count
    );

    modport master (
        output start, abort, target, target_length, worker_word_length, worker_password,
        input  worker_enable, worker_start_pos, worker_increment, busy, found, exhausted,
               result_password, result_worker, cycle_count
    );
endinterface

// File: rtl/bruteforce_scheduler.sv
// Sequences a bank of brute-force engines: interleaved start characters, a common stride,
// a registered compare stage, and a halt on first match, length overflow or timeout.
module bruteforce_lane_cmp #(
    parameter int MAX_LEN = 16
) (
    input  logic [127:0] password,
    input  logic [7:0]   word_length,
    input  logic [127:0] target,
    input  logic [7:0]   target_length,
    output logic         match,
    output logic         over
);
    assign match = (password == target) && (word_length == target_length);
    assign over  = word_length > 8'(MAX_LEN);
endmodule

module bruteforce_scheduler #(
    parameter int          NUM_WORKERS = 4,
    parameter int          MAX_LEN     = 16,
    parameter logic [31:0] TIMEOUT     = 32'hFFFF_FFFF,
    parameter int          LOAD_CYCLES = 2
) (
    input  logic                  CLK100MHZ,
    input  logic                  reset,
    bruteforce_scheduler_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, FOUND, EXHAUSTED} state_t;
    localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    state_t                 state;
    logic [LW-1:0]          load_cnt;
    logic [127:0]           tgt_q;
    logic [7:0]             tgt_len_q;
    logic [NUM_WORKERS-1:0] match, over, match_q, over_q;
    logic                   cmp_vld;
    logic [127:0]           win_pw, win_pw_q;
    logic [2:0]             win_idx, win_idx_q;
    logic                   bad_len;

    for (genvar g = 0; g < NUM_WORKERS; g++) begin : g_lane
        bruteforce_lane_cmp #(.MAX_LEN(MAX_LEN)) u_cmp (
            .password      (bus.worker_password[g]),
            .word_length   (bus.worker_word_length[g]),
            .target        (tgt_q),
            .target_length (tgt_len_q),
            .match         (match[g]),
            .over          (over[g])
        );
        assign bus.worker_start_pos[g] = 8'h61 + 8'(g);
    end

    assign bus.worker_increment = 3'(NUM_WORKERS);
    assign bad_len = (tgt_len_q == 8'd0) || (tgt_len_q > 8'(MAX_LEN));

    // Lowest-index match is picked before the register so decide only needs a flag test.
    always_comb begin
        win_pw  = '0;
        win_idx = '0;
        for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
            if (match[i]) begin
                win_pw  = bus.worker_password[i];
                win_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state               <= IDLE;
            load_cnt            <= '0;
            tgt_q               <= '0;
            tgt_len_q           <= '0;
            match_q             <= '0;
            over_q              <= '0;
            win_pw_q            <= '0;
            win_idx_q           <= '0;
            cmp_vld             <= 1'b0;
            bus.worker_enable   <= '0;
            bus.busy            <= 1'b0;
            bus.found           <= 1'b0;
            bus.exhausted       <= 1'b0;
            bus.result_password <= '0;
            bus.result_worker   <= '0;
            bus.cycle_count     <= '0;
        end else begin
            match_q   <= match;
            over_q    <= over;
            win_pw_q  <= win_pw;
            win_idx_q <= win_idx;
            cmp_vld   <= 1'b0;
            if (bus.abort && bus.busy) begin
                state               <= IDLE;
                bus.worker_enable   <= '0;
                bus.busy            <= 1'b0;
                bus.result_password <= '0;
                bus.result_worker   <= '0;
            end else begin
                case (state)
                    IDLE, FOUND, EXHAUSTED: begin
                        if (bus.start && !bus.abort) begin
                            state               <= LOAD;
                            load_cnt            <= LW'(LOAD_CYCLES - 1);
                            tgt_q               <= bus.target;
                            tgt_len_q           <= bus.target_length;
                            bus.busy            <= 1'b1;
                            bus.found           <= 1'b0;
                            bus.exhausted       <= 1'b0;
                            bus.result_password <= '0;
                            bus.result_worker   <= '0;
                            bus.cycle_count     <= '0;
                        end
                    end
                    LOAD: begin
                        if (load_cnt == '0) begin
                            state             <= RUN;
                            bus.worker_enable <= '1;
                        end else begin
                            load_cnt <= load_cnt - 1'b1;
                        end
                    end
                    RUN: begin
                        // cmp_vld keeps stale compares from LOAD out of the decision.
                        if (cmp_vld && |match_q) begin
                            state               <= FOUND;
                            bus.found           <= 1'b1;
                            bus.busy            <= 1'b0;
                            bus.worker_enable   <= '0;
                            bus.result_password <= win_pw_q;
                            bus.result_worker   <= win_idx_q;
                        end else if ((cmp_vld && (|over_q || bad_len)) ||
                                     bus.cycle_count == TIMEOUT) begin
                            state             <= EXHAUSTED;
                            bus.exhausted     <= 1'b1;
                            bus.busy          <= 1'b0;
                            bus.worker_enable <= '0;
                        end else begin
                            cmp_vld <= 1'b1;
                            if (bus.cycle_count != '1)
                                bus.cycle_count <= bus.cycle_count + 32'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bruteforce_scheduler.sv
// Bench for bruteforce_scheduler: engine bank modelled as scripted match/overflow events,
// outcome predicted from the earliest decide cycle of each event class.
module tb_bruteforce_scheduler;
    localparam int         NW   = 4;
    localparam int         MAXL = 16;
    localparam int         TMO  = 100;
    localparam int         LDC  = 2;
    localparam logic [7:0] NONE = 8'hFF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bruteforce_scheduler_if #(.NUM_WORKERS(NW)) bus();

    bruteforce_scheduler #(
        .NUM_WORKERS(NW), .MAX_LEN(MAXL), .TIMEOUT(32'(TMO)), .LOAD_CYCLES(LDC)
    ) dut (
        .CLK100MHZ (clk),
        .reset     (reset),
        .bus       (bus)
    );

    // mc[i]: RUN cycle where engine i shows the target (NONE = never); ovf: RUN cycle of overflow.
    typedef struct {
        string            name;
        logic [NW-1:0][7:0] mc;
        logic [7:0]       ovf;
        logic [127:0]     tgt;
        logic [7:0]       tlen;
        logic             ef;
        int               ew;
        int               ecc;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_engines();
        for (int i = 0; i < NW; i++) begin
            bus.worker_password[i]    = '0;
            bus.worker_word_length[i] = '0;
        end
    endtask

    task automatic drive(input vec_t v, input int r);
        int oe;
        oe = -1;
        if (v.ovf != NONE && int'(v.ovf) == r)
            for (int i = 0; i < NW; i++)
                if (oe < 0 && int'(v.mc[i]) != r) oe = i;
        for (int i = 0; i < NW; i++) begin
            bus.worker_password[i]    = (int'(v.mc[i]) == r) ? v.tgt : v.tgt ^ 128'(r * 8 + i + 1);
            bus.worker_word_length[i] = (i == oe) ? 8'(MAXL + 1) : v.tlen;
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [31:0] mc, input logic [7:0] ovf,
                                input logic [127:0] tgt, input logic [7:0] tlen,
                                input logic ef, input int ew, input int ecc);
        vec_t v;
        v.name = nm; v.mc = mc; v.ovf = ovf; v.tgt = tgt; v.tlen = tlen;
        v.ef = ef; v.ew = ew; v.ecc = ecc;
        return v;
    endfunction

    // An event in RUN cycle T is acted on in RUN cycle T+1; the earliest wins, match on ties.
    function automatic void predict(input vec_t v, output logic f, output int w, output int cc);
        int dm, dx;
        dm = 1000;
        dx = TMO;
        w  = 0;
        for (int i = 0; i < NW; i++)
            if (v.mc[i] != NONE && int'(v.mc[i]) + 1 < dm) begin
                dm = int'(v.mc[i]) + 1;
                w  = i;
            end
        if (v.ovf != NONE && int'(v.ovf) + 1 < dx) dx = int'(v.ovf) + 1;
        if ((v.tlen == 8'd0 || v.tlen > 8'(MAXL)) && dx > 1) dx = 1;
        f  = (dm <= dx);
        cc = f ? dm : dx;
    endfunction

    task automatic start_search(input vec_t v, output int load);
        bus.target        = v.tgt;
        bus.target_length = v.tlen;
        bus.start         = 1'b1;
        step();
        bus.start = 1'b0;
        chk({v.name, ".start_busy"}, 128'(bus.busy), 128'(1));
        chk({v.name, ".start_flags"}, 128'({bus.found, bus.exhausted}), 128'(0));
        chk({v.name, ".start_cc"}, 128'(bus.cycle_count), 128'(0));
        chk({v.name, ".start_rp"}, bus.result_password, 128'(0));
        load = 0;
        while (bus.worker_enable == '0 && load < 10) begin
            load++;
            step();
        end
        chk({v.name, ".load_len"}, 128'(load), 128'(LDC));
        chk({v.name, ".run_en"}, 128'(bus.worker_enable), 128'(4'hF));
    endtask

    task automatic run_search(input vec_t v);
        int load, r;
        start_search(v, load);
        r = 0;
        while (bus.worker_enable != '0 && r < 200) begin
            drive(v, r);
            r++;
            step();
        end
        idle_engines();
        chk({v.name, ".run_cycles"}, 128'(r), 128'(v.ecc + 1));
        chk({v.name, ".found"}, 128'(bus.found), 128'(v.ef));
        chk({v.name, ".exhausted"}, 128'(bus.exhausted), 128'(!v.ef));
        chk({v.name, ".result_worker"}, 128'(bus.result_worker), 128'(v.ef ? v.ew : 0));
        chk({v.name, ".result_password"}, bus.result_password, v.ef ? v.tgt : 128'(0));
        chk({v.name, ".cycle_count"}, 128'(bus.cycle_count), 128'(v.ecc));
        chk({v.name, ".end_busy"}, 128'(bus.busy), 128'(0));
        chk({v.name, ".end_en"}, 128'(bus.worker_enable), 128'(0));
    endtask

    initial begin
        vec_t tbl[9];
        vec_t v;
        int   load, r;

        tbl[0] = mk("eng0_at30",   {NONE, NONE, NONE, 8'd30},  NONE,  128'h6261, 8'd2,  1'b1, 0, 31);
        tbl[1] = mk("eng1_eng3",   {8'd12, NONE, 8'd12, NONE}, NONE,  128'h6261, 8'd2,  1'b1, 1, 13);
        tbl[2] = mk("ovf_only",    {NONE, NONE, NONE, NONE},   8'd20, 128'h6261, 8'd2,  1'b0, 0, 21);
        tbl[3] = mk("ovf_match",   {NONE, 8'd20, NONE, NONE},  8'd20, 128'h6261, 8'd2,  1'b1, 2, 21);
        tbl[4] = mk("timeout",     {NONE, NONE, NONE, NONE},   NONE,  128'h6261, 8'd2,  1'b0, 0, 100);
        tbl[5] = mk("tlen0",       {NONE, NONE, NONE, NONE},   NONE,  128'h61,   8'd0,  1'b0, 0, 1);
        tbl[6] = mk("tlen20_match",{8'd0, NONE, NONE, NONE},   NONE,  128'h7a79, 8'd20, 1'b1, 3, 1);
        tbl[7] = mk("match_at0",   {NONE, 8'd0, NONE, NONE},   NONE,  128'h636261, 8'd3, 1'b1, 2, 1);
        tbl[8] = mk("ovf_first",   {NONE, NONE, 8'd50, NONE},  8'd49, 128'h64, 8'd1,   1'b0, 0, 50);

        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.target = '0;
        bus.target_length = '0;
        idle_engines();
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst.en", 128'(bus.worker_enable), 128'(0));
        chk("rst.busy", 128'(bus.busy), 128'(0));
        chk("rst.flags", 128'({bus.found, bus.exhausted}), 128'(0));
        chk("rst.result", {bus.result_password[124:0], bus.result_worker}, 128'(0));
        chk("rst.cc", 128'(bus.cycle_count), 128'(0));
        chk("rst.start_pos", 128'(bus.worker_start_pos), 128'(32'h64636261));
        chk("rst.increment", 128'(bus.worker_increment), 128'(4));

        for (int i = 0; i < 9; i++) begin
            run_search(tbl[i]);
            if (i == 0) begin
                bus.abort = 1'b1;
                step();
                bus.abort = 1'b0;
                chk("abort_in_found.found", 128'(bus.found), 128'(1));
                chk("abort_in_found.rp", bus.result_password, 128'h6261);
            end
        end

        // start mid-RUN is ignored; abort together with start returns to IDLE
        v = mk("abort", {NONE, NONE, NONE, NONE}, NONE, 128'h6362, 8'd2, 1'b0, 0, 0);
        start_search(v, load);
        r = 0;
        while (bus.worker_enable != '0 && r < 10) begin
            drive(v, r);
            if (r == 5) bus.start = 1'b1;
            r++;
            step();
            bus.start = 1'b0;
        end
        chk("abort.cc_at10", 128'(bus.cycle_count), 128'(10));
        chk("abort.busy_before", 128'(bus.busy), 128'(1));
        drive(v, 10);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("abort.busy", 128'(bus.busy), 128'(0));
        chk("abort.en", 128'(bus.worker_enable), 128'(0));
        chk("abort.flags", 128'({bus.found, bus.exhausted}), 128'(0));
        chk("abort.result", bus.result_password, 128'(0));
        step();
        chk("abort.stays_idle", 128'(bus.busy), 128'(0));
        idle_engines();

        // synchronous reset in the middle of RUN
        v = mk("rst_mid", {NONE, NONE, NONE, NONE}, NONE, 128'h6261, 8'd2, 1'b0, 0, 0);
        start_search(v, load);
        for (int k = 0; k < 4; k++) begin
            drive(v, k);
            step();
        end
        reset = 1'b1;
        step();
        chk("rst_mid.en", 128'(bus.worker_enable), 128'(0));
        chk("rst_mid.busy", 128'(bus.busy), 128'(0));
        chk("rst_mid.cc", 128'(bus.cycle_count), 128'(0));
        chk("rst_mid.flags", 128'({bus.found, bus.exhausted}), 128'(0));
        reset = 1'b0;
        idle_engines();
        step();

        for (int k = 0; k < 25; k++) begin
            logic [NW-1:0][7:0] mc;
            logic ef;
            int ew, ecc;
            for (int i = 0; i < NW; i++)
                mc[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 110)) : NONE;
            v = mk($sformatf("rnd%0d", k), mc,
                   ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 110)) : NONE,
                   {$urandom, $urandom, $urandom, $urandom}, 8'($urandom_range(1, MAXL)),
                   1'b0, 0, 0);
            predict(v, ef, ew, ecc);
            v.ef = ef; v.ew = ew; v.ecc = ecc;
            run_search(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/bruteforce_scheduler.md
# bruteforce_scheduler

Controller that sequences a bank of `BruteForce` search engines. It partitions the first-character space by giving each engine its own starting character and a common stride. It runs the bank, compares every engine's candidate against a latched target each cycle, and halts the bank on the first match, on exhaustion of the word-length budget, or on a cycle timeout. It sits between the top-level control/UI logic and the engine array; the engines themselves are unchanged.

## Interface
- `NUM_WORKERS`, 4: number of engines; legal range 1..7, limited by the 3-bit stride.
- `MAX_LEN`, 16: largest word length searched; 1..16.
- `TIMEOUT`, 32'hFFFF_FFFF: RUN cycles before forced exhaustion.
- `LOAD_CYCLES`, 2: cycles enables are held low during LOAD; minimum 1.
- `CLK100MHZ`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; latches the target and begins a search.
- `abort`  in  1  one-cycle pulse; stops the search and returns to IDLE.
- `target`  in  128  password sought: ASCII, first char in [7:0], zero-padded high.
- `target_length`  in  8  character count of `target`.
- `worker_enable`  out  NUM_WORKERS  per-engine enable.
- `worker_start_pos`  out  8*NUM_WORKERS  engine i start char in bits [8i+7:8i].
- `worker_increment`  out  3  common stride, always NUM_WORKERS.
- `worker_word_length`  in  8*NUM_WORKERS  engine i current length.
- `worker_password`  in  128*NUM_WORKERS  engine i current candidate.
- `busy`  out  1  high in LOAD and RUN.
- `found`  out  1  search ended on a match.
- `exhausted`  out  1  search ended without a match.
- `result_password`  out  128  matching candidate.
- `result_worker`  out  3  index of the winning engine.
- `cycle_count`  out  32  RUN cycles elapsed in the current or last search.

## Operation
- States: IDLE, LOAD, RUN, FOUND, EXHAUSTED.
- `worker_start_pos[i]` = "a" + i, constant. `worker_increment` = NUM_WORKERS, constant.
- **IDLE**
  - `start` latches `target` and `target_length`, clears `found`, `exhausted`, `cycle_count` and results, then goes to LOAD.
- **LOAD**
  - `worker_enable` = 0 for LOAD_CYCLES cycles. Engines reload their start position while disabled.
  - Then RUN.
- **RUN**
  - `worker_enable` = all ones; `cycle_count` increments every cycle, saturating at all-ones.
  - Compare stage, registered: `match_q[i]` = (`worker_password[i]` == target) AND (`worker_word_length[i]` == target_length). The winning password is registered alongside.
  - Decide stage, evaluated on the registered values:
    - Any `match_q` bit set: go to FOUND. The lowest set index wins and is captured into `result_worker` and `result_password`.
    - Otherwise, any registered word length > MAX_LEN, or `cycle_count` == TIMEOUT: go to EXHAUSTED.
    - Match and exhaustion in the same cycle: FOUND wins.
- **FOUND / EXHAUSTED**
  - Enables 0; the respective flag is held high and results are held.
  - `start` restarts the search exactly as from IDLE.
- `abort` in LOAD or RUN: go to IDLE, enables 0, flags stay 0, results cleared.
- `abort` in other states: no effect.
- `start` in LOAD or RUN: ignored. `start` and `abort` in the same cycle: `abort` wins.
- `target_length` of 0 or > MAX_LEN: goes to EXHAUSTED on the first decide cycle unless an engine reports a matching length.

## Timing
- Reset values: state IDLE, `worker_enable` 0, `busy` 0, `found` 0, `exhausted` 0, `result_password` 0, `result_worker` 0, `cycle_count` 0. Reset mid-search behaves identically; engines are disabled on the next edge.
- `start` sampled at edge E: `busy` = 1 and LOAD entered after E. Enables rise after edge E+LOAD_CYCLES.
- Engine candidate equal to target in cycle T:
  - `match_q` is set after edge T+1.
  - `found` = 1 and `worker_enable` = 0 after edge T+2.
  - Engines therefore advance at most 2 further steps past the match; `result_password` is the registered copy, not the live value.
- Exhaustion has the same 2-cycle latency from the offending word length.
- `abort` takes effect on the next edge; there is no drain.

## Test plan
- NUM_WORKERS=4, target "ab", length 2. Engine 0 model produces "ab" at RUN cycle 30 -> `found`=1 two cycles later, `result_worker`=0, `result_password`="ab", `busy`=0, all enables 0.
- Engines 1 and 3 match in the same cycle -> `result_worker`=1.
- Engine word length reaches MAX_LEN+1 with no match -> `exhausted`=1 after 2 cycles, `found`=0. Repeat with a match in that same cycle -> `found`=1, `exhausted`=0.
- TIMEOUT=100, no match -> `exhausted`=1, `cycle_count`=100. Pulse `start` again -> flags clear, LOAD lasts exactly 2 cycles, then RUN.
- `abort` at RUN cycle 10 -> IDLE next edge, enables 0, `found`=0, `exhausted`=0. Pulse `start` during RUN -> ignored. Assert `reset` mid-RUN -> all outputs at reset values after one edge.
- After reset: `worker_start_pos` reads "a","b","c","d" and `worker_increment`=4.
